countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 68 ++++++
 tb/tb_countdown_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with start/pause/resume control and optional auto-reload
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   load        capture load_value into count and the reload register, abort any run
//   load_value  duration to load (WIDTH bits)
//   start       start from IDLE (when count != 0) or resume from PAUSED
//   pause       suspend counting while running
//   count       registered remaining count
//   busy        high while running or paused
//   done        one-cycle pulse when the count expires
module countdown_timer #(
  parameter int WIDTH  = 4,
  parameter bit RELOAD = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] reload_reg, count_nxt;
  logic done_nxt;
  logic expire, rearm;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= done_nxt;
      if (load) reload_reg <= load_value;
    end
  end
  // expire: the decrementing edge that takes the count to zero
  assign expire = (state == RUN) && !load && !pause && (count == WIDTH'(1));
  // a zero reload value never re-arms, so RUN is never held at zero
  assign rearm  = RELOAD && (reload_reg != '0);
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = expire;
    if (load) begin
      state_nxt = IDLE;
      count_nxt = load_value;
    end else begin
      case (state)
        IDLE:    state_nxt = (start && count != '0) ? RUN : IDLE;
        RUN: begin
          state_nxt = pause ? PAUSED : (expire && !rearm) ? IDLE : RUN;
          count_nxt = pause ? count : expire ? (rearm ? reload_reg : '0) : count - WIDTH'(1);
        end
        PAUSED:  state_nxt = start ? RUN : PAUSED;
        default: state_nxt = IDLE;
      endcase
    end
  end
  always_comb busy = (state != IDLE);
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table, directed and randomized checks of countdown_timer in both reload modes
module tb_countdown_timer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] load_value = '0;
  logic [3:0] c0, c1;
  logic b0, b1, d0, d1;
  int tests = 0, fails = 0;

  countdown_timer #(.WIDTH(4), .RELOAD(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(c0), .busy(b0), .done(d0));
  countdown_timer #(.WIDTH(4), .RELOAD(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(c1), .busy(b1), .done(d1));

  always #5 clock = ~clock;

  // reference: mode 0=idle 1=running 2=paused, remaining cycles, stored duration
  int m_mode[2], m_cnt[2], m_dur[2];
  bit m_done[2];

  function automatic void model_reset();
    for (int r = 0; r < 2; r++) begin
      m_mode[r] = 0; m_cnt[r] = 0; m_dur[r] = 0; m_done[r] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int r = 0; r < 2; r++) begin
      m_done[r] = 0;
      if (load) begin
        m_cnt[r] = int'(load_value); m_dur[r] = int'(load_value); m_mode[r] = 0;
      end else if (m_mode[r] == 0) begin
        if (start && m_cnt[r] > 0) m_mode[r] = 1;
      end else if (m_mode[r] == 1) begin
        if (pause) m_mode[r] = 2;
        else begin
          m_cnt[r] = m_cnt[r] - 1;
          if (m_cnt[r] == 0) begin
            m_done[r] = 1;
            if (r == 1 && m_dur[r] > 0) m_cnt[r] = m_dur[r];
            else m_mode[r] = 0;
          end
        end
      end else if (start) m_mode[r] = 1;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model count r0", 32'(c0), 32'(m_cnt[0]));
    chk("model busy r0", 32'(b0), 32'(m_mode[0] != 0));
    chk("model done r0", 32'(d0), 32'(m_done[0]));
    chk("model count r1", 32'(c1), 32'(m_cnt[1]));
    chk("model busy r1", 32'(b1), 32'(m_mode[1] != 0));
    chk("model done r1", 32'(d1), 32'(m_done[1]));
  endtask

  task automatic step(input logic l, input logic [3:0] lv, input logic s, input logic p);
    @(negedge clock);
    load = l; load_value = lv; start = s; pause = p;
    @(posedge clock);
    model_edge();
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    load = 0; start = 0; pause = 0; load_value = '0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic l; logic [3:0] lv; logic s; logic p;
    logic [3:0] c; logic b; logic d;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int n, dones;
    logic [3:0] exp_c;
    tbl[0]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd4, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 4'd2, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};

    model_reset();
    #2;
    chk("reset count", 32'(c0), 0);
    chk("reset busy", 32'(b0), 0);
    chk("reset done", 32'(d0), 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].l, tbl[i].lv, tbl[i].s, tbl[i].p);
      chk($sformatf("vec%0d count", i), 32'(c0), 32'(tbl[i].c));
      chk($sformatf("vec%0d busy", i), 32'(b0), 32'(tbl[i].b));
      chk($sformatf("vec%0d done", i), 32'(d0), 32'(tbl[i].d));
    end

    // asynchronous reset while running at count 5
    step(1, 4'd7, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pre-reset count", 32'(c0), 5);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset count", 32'(c0), 0);
    chk("async reset busy", 32'(b0), 0);
    chk("async reset done", 32'(d0), 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("idle after reset busy", 32'(b0), 0);

    // pause/resume delays done by the cycles spent paused
    step(1, 4'd6, 0, 0);
    step(0, 0, 1, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 0); n++; end
    chk("pre-pause count", 32'(c0), 3);
    step(0, 0, 0, 1); n++;
    step(0, 0, 0, 0); n++;
    step(0, 0, 0, 0); n++;
    chk("paused hold count", 32'(c0), 3);
    step(0, 0, 1, 0); n++;
    chk("resume edge count", 32'(c0), 3);
    while (d0 !== 1'b1 && n < 30) begin step(0, 0, 0, 0); n++; end
    chk("pause latency", 32'(n), 10);

    // auto-reload period 3
    do_reset();
    step(1, 4'd3, 0, 0);
    step(0, 0, 1, 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0);
      exp_c = 4'(3 - ((i + 1) % 3));
      chk($sformatf("reload seq %0d", i), 32'(c1), 32'(exp_c));
      chk("reload busy", 32'(b1), 1);
      dones += int'(d1);
    end
    chk("reload done count", 32'(dones), 4);

    // reload value 1: done every cycle
    step(1, 4'd1, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      chk("reload1 done", 32'(d1), 1);
    end

    // full-width load, no underflow
    step(1, 4'd15, 0, 0);
    step(0, 0, 1, 0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      dones += int'(d0);
    end
    chk("wrap done count", 32'(dones), 1);
    chk("wrap final count", 32'(c0), 0);

    // randomized against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic l, s, p;
      l = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 3) == 0);
      p = !s && ($urandom_range(0, 5) == 0);
      step(l, 4'($urandom_range(0, 15)), s, p);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
